uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter BAUD_DIV, default 5208, SHALL set clocks per bit period; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, SHALL select parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits checked per frame; legal values 1 or 2.
REQ-005 s_clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 s_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 uart_rx  input  1  SHALL be the asynchronous serial line; idle high.
REQ-008 m_data  output  DATA_BITS  SHALL carry the received word, LSB first on the line.
REQ-009 m_valid  output  1  SHALL flag that m_data, m_perr and m_ferr hold an unconsumed frame.
REQ-010 m_ready  input  1  SHALL be the consumer accept; transfer occurs when m_valid and m_ready are both high.
REQ-011 m_perr  output  1  SHALL flag a parity mismatch for the held frame; 0 when PARITY=0.
REQ-012 m_ferr  output  1  SHALL flag any stop bit sampled low for the held frame.
REQ-013 overrun  output  1  SHALL pulse high for one cycle when a completed frame is dropped.

Function
REQ-014 uart_rx SHALL pass a 2-flop synchronizer; the start edge is a 1-to-0 transition at the synchronizer output.
REQ-015 Baud counter SHALL count 0..BAUD_DIV-1 and wrap; MID = BAUD_DIV/2.
REQ-016 Each bit SHALL be decided by 2-of-3 majority vote of samples taken at counts MID-1, MID, MID+1.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START on start edge; baud counter cleared to 0 on the same cycle.
REQ-019 START: majority 1 at MID SHALL be a false start -> IDLE, no output and no flag; majority 0 -> DATA at wrap.
REQ-020 DATA: SHALL shift in DATA_BITS bits LSB-first; bit counter wraps to 0; -> PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: expected bit = XOR of data bits, inverted for odd; mismatch sets the frame's perr.
REQ-022 STOP: each stop bit is decided at MID+1; a 0 sets the frame's ferr. After the last stop-bit decision, -> IDLE immediately, without waiting for the wrap, so back-to-back frames are accepted.
REQ-023 Frame completion SHALL occur on the cycle after the last stop-bit decision; m_valid rises on that cycle if the holding register is free.
REQ-024 Holding register is 1 entry; it frees on a handshake. A completion coinciding with a handshake SHALL load the new frame, leaving m_valid high with no gap.
REQ-025 Completion while m_valid=1 and m_ready=0: the new frame SHALL be discarded, the held frame kept, and overrun pulsed for 1 cycle.
REQ-026 m_data, m_perr and m_ferr SHALL remain stable while m_valid=1 and m_ready=0.
REQ-027 A frame with ferr=1 SHALL still be delivered, with the received data.

Reset
REQ-028 s_rst SHALL set FSM=IDLE, all counters to 0, m_data to 0, and m_valid, m_perr, m_ferr and overrun to 0.
REQ-029 Synchronizer flops SHALL reset to 1 so that no false start edge follows reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no output; reception resumes on the next start edge after release.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the parity-mode constants (NONE/ODD/EVEN) and the 2-of-3 majority function.
REQ-032 Sub-module uart_rx_sampler SHALL contain the synchronizer, edge detect and majority capture; the FSM, counters and holding register stay in uart_rx_cfg.

Verification (BAUD_DIV=16 unless stated)
REQ-033 8N1 frame 0x55, m_ready=1 -> m_data=0x55 and m_valid for exactly 1 cycle, 152-156 clocks after uart_rx falls; perr=ferr=0.
REQ-034 PARITY=2, 0xA3 sent with parity bit 1 -> m_perr=1; the same frame with parity bit 0 -> m_perr=0; m_data=0xA3 in both cases.
REQ-035 Stop bit driven 0 for 0x0F -> m_data=0x0F, m_ferr=1; next frame 0xF0, sent back-to-back, -> ferr=0.
REQ-036 m_ready=0, frames 0x11 then 0x22 -> m_data holds 0x11, overrun pulses once; m_ready=1 -> 0x11 transfers and 0x22 is never seen.
REQ-037 Glitch: uart_rx low for 4 clocks -> no m_valid; single-clock 1-spikes at MID inside data bits of 0x3C -> m_data=0x3C.
REQ-038 s_rst asserted during DATA bit 4, then frame 0x7E sent -> only 0x7E delivered; DATA_BITS=5, STOP_BITS=2, frame 0x15 -> m_data=0x15.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, parity-mode constants and vote helper for uart_rx_cfg
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_ODD  = 1;
    localparam int c_PAR_EVEN = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg_if
//  Purpose  : Valid/ready frame output bundle of the UART receiver
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_perr;
    logic                 m_ferr;

    modport master (output m_data, output m_valid, output m_perr, output m_ferr,
                    input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_perr, input  m_ferr,
                    output m_ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Purpose  : Line synchronizer, start-edge detect and 3-sample majority vote
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] MID   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_rx,
    input  wire logic [CNT_W-1:0] i_cnt,
    output logic                  o_fall,
    output logic                  o_bit
);

    localparam logic [CNT_W-1:0] c_MID_M1 = MID - 1'b1;

    logic r_meta_q, r_sync_q, r_prev_q, r_smp0_q, r_smp1_q;
    logic w_smp0_d, w_smp1_d;

    always_comb begin
        w_smp0_d = r_smp0_q;
        w_smp1_d = r_smp1_q;
        if (i_cnt == c_MID_M1) w_smp0_d = r_sync_q;
        if (i_cnt == MID)      w_smp1_d = r_sync_q;
    end

    // Everything resets to the idle-line level so release never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
            r_prev_q <= 1'b1;
            r_smp0_q <= 1'b1;
            r_smp1_q <= 1'b1;
        end else begin
            r_meta_q <= i_rx;
            r_sync_q <= r_meta_q;
            r_prev_q <= r_sync_q;
            r_smp0_q <= w_smp0_d;
            r_smp1_q <= w_smp1_d;
        end
    end

    // The third vote sample is the live synchronizer output at MID+1.
    assign o_fall = r_prev_q & ~r_sync_q;
    assign o_bit  = maj3(r_smp0_q, r_smp1_q, r_sync_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Purpose  : Configurable UART receiver with parity/framing flags and a
//             single-entry valid/ready holding register
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  wire logic        s_clk,
    input  wire logic        s_rst,
    input  wire logic        uart_rx,
    output logic             overrun,
    uart_rx_cfg_if.master    m_if
);

    localparam logic [15:0] c_LAST      = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_MID       = 16'(BAUD_DIV / 2);
    localparam logic [15:0] c_DECIDE    = c_MID + 16'd1;
    localparam logic [3:0]  c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  c_STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state_q, w_state_d;
    logic [15:0]          r_cnt_q,   w_cnt_d;
    logic [3:0]           r_bit_q,   w_bit_d;
    logic [DATA_BITS-1:0] r_shift_q, w_shift_d;
    logic                 r_par_q,   w_par_d;
    logic                 r_perr_q,  w_perr_d;
    logic                 r_ferr_q,  w_ferr_d;
    logic [DATA_BITS-1:0] r_data_q,  w_data_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_hperr_q, w_hperr_d;
    logic                 r_hferr_q, w_hferr_d;
    logic                 r_ovr_q,   w_ovr_d;

    logic w_fall, w_vote, w_wrap, w_decide, w_frame_done, w_par_exp;

    uart_rx_sampler #(
        .CNT_W (16),
        .MID   (c_MID)
    ) u_sampler (
        .clk    (s_clk),
        .rst    (s_rst),
        .i_rx   (uart_rx),
        .i_cnt  (r_cnt_q),
        .o_fall (w_fall),
        .o_bit  (w_vote)
    );

    assign w_wrap       = (r_cnt_q == c_LAST);
    assign w_decide     = (r_cnt_q == c_DECIDE);
    assign w_frame_done = (r_state_q == S_STOP) && w_decide && (r_bit_q == c_STOP_LAST);
    assign w_par_exp    = (PARITY == c_PAR_ODD) ? ~r_par_q : r_par_q;

    // State register
    always_ff @(posedge s_clk) begin
        if (s_rst) r_state_q <= S_IDLE;
        else       r_state_q <= w_state_d;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:   if (w_fall) w_state_d = S_START;
            S_START: begin
                if (w_decide && w_vote) w_state_d = S_IDLE;
                else if (w_wrap)        w_state_d = S_DATA;
            end
            S_DATA: begin
                if (w_wrap && (r_bit_q == c_DATA_LAST))
                    w_state_d = (PARITY != c_PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_wrap) w_state_d = S_STOP;
            // Leave on the last stop decision so a following start bit is not missed.
            S_STOP:   if (w_frame_done) w_state_d = S_IDLE;
            default:  w_state_d = S_IDLE;
        endcase
    end

    // Counters, frame accumulation and holding register
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_par_d   = r_par_q;
        w_perr_d  = r_perr_q;
        w_ferr_d  = r_ferr_q;
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_hperr_d = r_hperr_q;
        w_hferr_d = r_hferr_q;
        w_ovr_d   = 1'b0;

        if (r_state_q == S_IDLE)       w_cnt_d = w_fall ? 16'd1 : 16'd0;
        else if (w_state_d == S_IDLE)  w_cnt_d = 16'd0;
        else                           w_cnt_d = w_wrap ? 16'd0 : r_cnt_q + 16'd1;

        case (r_state_q)
            S_IDLE: begin
                w_bit_d = 4'd0;
                if (w_fall) begin
                    w_par_d  = 1'b0;
                    w_perr_d = 1'b0;
                    w_ferr_d = 1'b0;
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    w_shift_d = {w_vote, r_shift_q[DATA_BITS-1:1]};
                    w_par_d   = r_par_q ^ w_vote;
                end
                if (w_wrap) w_bit_d = (r_bit_q == c_DATA_LAST) ? 4'd0 : r_bit_q + 4'd1;
            end
            S_PARITY: if (w_decide) w_perr_d = (w_vote != w_par_exp);
            S_STOP: begin
                if (w_decide && !w_vote) w_ferr_d = 1'b1;
                if (w_wrap)              w_bit_d  = r_bit_q + 4'd1;
                if (w_frame_done)        w_bit_d  = 4'd0;
            end
            default: ;
        endcase

        if (r_valid_q && m_if.m_ready) w_valid_d = 1'b0;

        // A completing frame takes the slot if it is empty or being handed off now.
        if (w_frame_done) begin
            if (!r_valid_q || m_if.m_ready) begin
                w_data_d  = r_shift_q;
                w_hperr_d = r_perr_q;
                w_hferr_d = r_ferr_q | ~w_vote;
                w_valid_d = 1'b1;
            end else begin
                w_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_cnt_q   <= 16'd0;
            r_bit_q   <= 4'd0;
            r_shift_q <= '0;
            r_par_q   <= 1'b0;
            r_perr_q  <= 1'b0;
            r_ferr_q  <= 1'b0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_hperr_q <= 1'b0;
            r_hferr_q <= 1'b0;
            r_ovr_q   <= 1'b0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_par_q   <= w_par_d;
            r_perr_q  <= w_perr_d;
            r_ferr_q  <= w_ferr_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_hperr_q <= w_hperr_d;
            r_hferr_q <= w_hferr_d;
            r_ovr_q   <= w_ovr_d;
        end
    end

    assign m_if.m_data  = r_data_q;
    assign m_if.m_valid = r_valid_q;
    assign m_if.m_perr  = r_hperr_q;
    assign m_if.m_ferr  = r_hferr_q;
    assign overrun      = r_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg
//  Purpose  : Directed bench for uart_rx_cfg in 8N1, 8E1 and 5N2 configurations
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

    logic clk;
    logic rst;
    logic rx_a, rx_p, rx_b;
    logic ovr_a, ovr_p, ovr_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_fall = 0;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_p ();
    uart_rx_cfg_if #(.DATA_BITS(5)) if_b ();

    uart_rx_cfg #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .s_clk(clk), .s_rst(rst), .uart_rx(rx_a), .overrun(ovr_a), .m_if(if_a));
    uart_rx_cfg #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .s_clk(clk), .s_rst(rst), .uart_rx(rx_p), .overrun(ovr_p), .m_if(if_p));
    uart_rx_cfg #(.BAUD_DIV(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dut_b (
        .s_clk(clk), .s_rst(rst), .uart_rx(rx_b), .overrun(ovr_b), .m_if(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor for the 8N1 instance, sampled between stimulus and the next edge
    logic [7:0] a_dq[$];
    logic       a_fq[$];
    logic       a_pq[$];
    int         a_vcnt  = 0;
    int         a_vrise = 0;
    int         a_ovcnt = 0;
    logic       a_vprev = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (if_a.m_valid) begin
            a_vcnt = a_vcnt + 1;
            if (!a_vprev) a_vrise = cyc;
        end
        a_vprev = if_a.m_valid;
        if (if_a.m_valid && if_a.m_ready) begin
            a_dq.push_back(if_a.m_data);
            a_fq.push_back(if_a.m_ferr);
            a_pq.push_back(if_a.m_perr);
        end
        if (ovr_a) a_ovcnt = a_ovcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_b = v;
        endcase
    endtask

    task automatic hold_line(input int which, input logic v, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive(which, v);
        end
    endtask

    // bits[] is the whole frame LSB-first including start/parity/stop; spikes hit data bits at MID
    task automatic send(input int which, input logic [15:0] bits, input int n, input bit spike);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) t_fall = cyc;
                drive(which, (spike && c == 8 && i >= 1 && i <= 8) ? 1'b1 : bits[i]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base, vbase, obase, lat;

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
        if_a.m_ready = 1'b0; if_p.m_ready = 1'b0; if_b.m_ready = 1'b0;
        idle(4);
        rst = 1'b0;
        idle(3);

        chk("rst_valid_a", {31'd0, if_a.m_valid}, 32'd0);
        chk("rst_data_a",  {24'd0, if_a.m_data},  32'd0);
        chk("rst_perr_a",  {31'd0, if_a.m_perr},  32'd0);
        chk("rst_ferr_a",  {31'd0, if_a.m_ferr},  32'd0);
        chk("rst_ovr_a",   {31'd0, ovr_a},        32'd0);
        chk("rst_valid_p", {31'd0, if_p.m_valid}, 32'd0);
        chk("rst_valid_b", {31'd0, if_b.m_valid}, 32'd0);

        // 8N1 0x55 with a ready consumer: one-cycle valid at fixed latency
        if_a.m_ready = 1'b1;
        vbase = a_vcnt;
        send(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10, 0);
        idle(8);
        lat = a_vrise - t_fall;
        chk("n_frames_55", 32'(a_dq.size()), 32'd1);
        chk("data_55",     {24'd0, a_dq[0]}, 32'h55);
        chk("ferr_55",     {31'd0, a_fq[0]}, 32'd0);
        chk("perr_55",     {31'd0, a_pq[0]}, 32'd0);
        chk("vcycles_55",  32'(a_vcnt - vbase), 32'd1);
        chk("lat_55_in_152_156", {31'd0, (lat >= 152 && lat <= 156)}, 32'd1);

        // Low stop bit on 0x0F; the line must return high briefly before 0xF0's start edge
        base = a_dq.size();
        send(0, {6'd0, 1'b0, 8'h0F, 1'b0}, 10, 0);
        hold_line(0, 1'b1, 4);
        send(0, {6'd0, 1'b1, 8'hF0, 1'b0}, 10, 0);
        idle(8);
        chk("n_frames_ferr", 32'(a_dq.size() - base), 32'd2);
        chk("data_0f", {24'd0, a_dq[base]},     32'h0F);
        chk("ferr_0f", {31'd0, a_fq[base]},     32'd1);
        chk("data_f0", {24'd0, a_dq[base+1]},   32'hF0);
        chk("ferr_f0", {31'd0, a_fq[base+1]},   32'd0);

        // Short low glitch is a false start
        vbase = a_vcnt;
        hold_line(0, 1'b0, 4);
        hold_line(0, 1'b1, 40);
        chk("glitch_no_valid", 32'(a_vcnt - vbase), 32'd0);

        // One-cycle high spikes at the middle of each data bit are voted out
        base = a_dq.size();
        send(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1);
        idle(8);
        chk("n_frames_3c", 32'(a_dq.size() - base), 32'd1);
        chk("data_3c",     {24'd0, a_dq[base]},     32'h3C);

        // Back-to-back frames into a stalled consumer: second frame is dropped
        if_a.m_ready = 1'b0;
        base  = a_dq.size();
        obase = a_ovcnt;
        send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10, 0);
        send(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10, 0);
        idle(4);
        chk("ovr_valid_held", {31'd0, if_a.m_valid}, 32'd1);
        chk("ovr_data_held",  {24'd0, if_a.m_data},  32'h11);
        chk("ovr_pulses",     32'(a_ovcnt - obase),  32'd1);
        chk("ovr_no_xfer",    32'(a_dq.size() - base), 32'd0);
        if_a.m_ready = 1'b1;
        idle(1);
        idle(2);
        chk("ovr_xfer_count", 32'(a_dq.size() - base), 32'd1);
        chk("ovr_xfer_data",  {24'd0, a_dq[base]},     32'h11);
        chk("ovr_valid_clr",  {31'd0, if_a.m_valid},   32'd0);
        idle(40);
        chk("ovr_22_never", 32'(a_dq.size() - base), 32'd1);

        // Reset in the middle of data bit 4 aborts that frame
        send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 5, 0);
        hold_line(0, 1'b0, 8);
        rst  = 1'b1;
        rx_a = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(10);
        chk("midrst_valid", {31'd0, if_a.m_valid}, 32'd0);
        chk("midrst_data",  {24'd0, if_a.m_data},  32'd0);
        base = a_dq.size();
        send(0, {6'd0, 1'b1, 8'h7E, 1'b0}, 10, 0);
        idle(8);
        chk("after_rst_count", 32'(a_dq.size() - base), 32'd1);
        chk("after_rst_data",  {24'd0, a_dq[base]},     32'h7E);

        // Even parity, 0xA3 has four ones: parity bit 1 is wrong, 0 is right
        send(1, {5'd0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11, 0);
        idle(5);
        chk("par1_valid", {31'd0, if_p.m_valid}, 32'd1);
        chk("par1_data",  {24'd0, if_p.m_data},  32'hA3);
        chk("par1_perr",  {31'd0, if_p.m_perr},  32'd1);
        chk("par1_ferr",  {31'd0, if_p.m_ferr},  32'd0);
        if_p.m_ready = 1'b1;
        idle(1);
        if_p.m_ready = 1'b0;
        idle(2);
        chk("par_consumed", {31'd0, if_p.m_valid}, 32'd0);
        send(1, {5'd0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11, 0);
        idle(5);
        chk("par0_valid", {31'd0, if_p.m_valid}, 32'd1);
        chk("par0_data",  {24'd0, if_p.m_data},  32'hA3);
        chk("par0_perr",  {31'd0, if_p.m_perr},  32'd0);

        // Five data bits, two stop bits
        send(2, {8'd0, 2'b11, 5'h15, 1'b0}, 8, 0);
        idle(5);
        chk("b5_valid", {31'd0, if_b.m_valid}, 32'd1);
        chk("b5_data",  {27'd0, if_b.m_data},  32'h15);
        chk("b5_ferr",  {31'd0, if_b.m_ferr},  32'd0);
        chk("b5_perr",  {31'd0, if_b.m_perr},  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
